uart_mem_bridge: RTL and testbench

- Bus-slave to serial-memory bridge. Turns single-beat read/write requests into framed command bytes for an external memory server reached over UART, and returns that server's responses.
- Successor to the first-generation main-memory bridge. Adds:
  - parametrised address/data widths;
  - a full READ/WRITE/ACK/RESEND protocol;
  - a response timeout with bounded retry;
  - an error report to the bus side.
- Sits between the CPU data bus and the UART tx/rx byte engines.

---
 rtl/uart_mem_pkg.sv | 26 ++
 rtl/uart_mem_timeout.sv | 32 +++
 rtl/uart_mem_bridge.sv | 208 ++++++++++++++++++++
 tb/tb_uart_mem_bridge.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mem_pkg.sv
// Shared types for the UART memory bridge: command codes, bridge states,
// and the bit-width to byte-count helper.
package uart_mem_pkg;

  typedef enum logic [7:0] {
    ACK    = 8'd1,
    RESEND = 8'd2,
    READ   = 8'd3,
    WRITE  = 8'd4
  } mem_cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_RESP,
    RECV_DATA,
    RETRY,
    DONE,
    FAIL
  } bridge_state_e;

  function automatic int unsigned byte_count(input int unsigned bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_mem_timeout.sv
// Saturating response timeout counter for the UART memory bridge.
// Counts while enabled, clears on demand, flags the last cycle of the window.
module uart_mem_timeout #(
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic clk,
  input  logic res,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  // Count enabled cycles, holding at the saturation value.
  always_ff @(posedge clk) begin
    if (!res) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != CNT_SAT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_mem_bridge.sv
// Bus-slave to UART memory-server bridge: frames single-beat read/write
// requests as command bytes, collects ACK/RESEND/data responses, retries on
// RESEND or timeout, and reports done/err to the bus side.
// Optional checksum bytes in both directions: define UART_MEM_CSUM_EN.
module uart_mem_bridge
  import uart_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic              clk,
  input  logic              res,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid
);

  localparam int unsigned AB = byte_count(ADDR_W);
  localparam int unsigned DB = DATA_W / 8;
`ifdef UART_MEM_CSUM_EN
  localparam int unsigned CS = 1;
`else
  localparam int unsigned CS = 0;
`endif
  localparam int unsigned FB = 1 + AB + DB + CS;
  localparam int unsigned IW = $clog2(FB + 1);
  localparam int unsigned RW = $clog2(DB + 2);
  localparam int unsigned TW = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] DB_CNT    = RW'(DB);
  localparam logic [TW-1:0] RETRY_MAX = TW'(MAX_RETRY);

  bridge_state_e    state, state_nx;
  logic [7:0]       frame    [FB];
  logic [7:0]       frame_nx [FB];
  logic [IW-1:0]    frame_last, frame_last_nx, idx;
  logic             is_write;
  logic [TW-1:0]    retry_cnt;
  logic [RW-1:0]    rx_cnt;
  logic [AB*8-1:0]  addr_ext;
  int unsigned      base_len;
  logic             tmo_clr, tmo_en, tmo_expire;
  logic             rx_ack, rx_resend;
`ifdef UART_MEM_CSUM_EN
  logic [7:0]       tx_csum;
  logic [7:0]       rx_csum;
`endif

  assign addr_ext  = (AB*8)'(addr);
  assign rx_ack    = rx_valid && (rx_data == ACK);
  assign rx_resend = rx_valid && (rx_data == RESEND);

  uart_mem_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .res    (res),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  // Build the outgoing frame (command, address, data, optional checksum) from the bus request.
  always_comb begin
    for (int unsigned k = 0; k < FB; k++) frame_nx[k] = '0;
    frame_nx[0] = we ? WRITE : READ;
    for (int unsigned i = 0; i < AB; i++) frame_nx[1+i] = addr_ext[(AB-1-i)*8 +: 8];
    if (we) begin
      for (int unsigned i = 0; i < DB; i++) frame_nx[1+AB+i] = wdata[(DB-1-i)*8 +: 8];
    end
    base_len = we ? (1 + AB + DB) : (1 + AB);
`ifdef UART_MEM_CSUM_EN
    // Unused data slots are zero, so XOR over the whole array equals XOR over the frame.
    tx_csum = '0;
    for (int unsigned k = 0; k < FB; k++) tx_csum = tx_csum ^ frame_nx[k];
    frame_nx[base_len] = tx_csum;
    frame_last_nx = IW'(base_len);
`else
    frame_last_nx = IW'(base_len - 1);
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!res) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state and output decode.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    tmo_clr  = 1'b0;
    tmo_en   = 1'b0;
    case (state)
      IDLE: if (req) state_nx = SEND;
      SEND: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = frame[idx];
        if (tx_ready && idx == frame_last) begin
          tmo_clr  = 1'b1;
          state_nx = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        busy   = 1'b1;
        tmo_en = 1'b1;
        if (rx_ack) begin
          if (is_write) begin
            state_nx = DONE;
          end else begin
            tmo_clr  = 1'b1;
            state_nx = RECV_DATA;
          end
        end else if (rx_resend || tmo_expire) begin
          state_nx = RETRY;
        end
      end
      RECV_DATA: begin
        busy   = 1'b1;
        tmo_en = 1'b1;
        if (rx_valid) begin
          tmo_clr = 1'b1;
`ifdef UART_MEM_CSUM_EN
          if (rx_cnt == DB_CNT) state_nx = (rx_data == rx_csum) ? DONE : RETRY;
`else
          if (rx_cnt == DB_CNT - 1'b1) state_nx = DONE;
`endif
        end else if (tmo_expire) begin
          state_nx = RETRY;
        end
      end
      RETRY: begin
        busy     = 1'b1;
        state_nx = (retry_cnt < RETRY_MAX) ? SEND : FAIL;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      FAIL: begin
        err      = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Frame, byte index, retry count and response assembly registers.
  always_ff @(posedge clk) begin
    if (!res) begin
      for (int unsigned k = 0; k < FB; k++) frame[k] <= '0;
      frame_last <= '0;
      is_write   <= 1'b0;
      idx        <= '0;
      retry_cnt  <= '0;
      rx_cnt     <= '0;
      rdata      <= '0;
`ifdef UART_MEM_CSUM_EN
      rx_csum    <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (req) begin
          frame      <= frame_nx;
          frame_last <= frame_last_nx;
          is_write   <= we;
          idx        <= '0;
          retry_cnt  <= '0;
        end
        SEND: if (tx_ready) idx <= idx + 1'b1;
        WAIT_RESP: if (rx_ack) begin
          rx_cnt <= '0;
`ifdef UART_MEM_CSUM_EN
          rx_csum <= ACK;
`endif
        end
        RECV_DATA: if (rx_valid && rx_cnt < DB_CNT) begin
          rdata  <= DATA_W'({rdata, rx_data});
          rx_cnt <= rx_cnt + 1'b1;
`ifdef UART_MEM_CSUM_EN
          rx_csum <= rx_csum ^ rx_data;
`endif
        end
        RETRY: if (retry_cnt < RETRY_MAX) begin
          retry_cnt <= retry_cnt + 1'b1;
          idx       <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Self-checking bench for uart_mem_bridge (ADDR_W=16, DATA_W=32, MAX_RETRY=2, TIMEOUT_CYC=100).
// Expected tx bytes are queued by the stimulus; a negedge monitor checks every handshake,
// byte stability under backpressure, and every done/err pulse against bench expectations.
module tb_uart_mem_bridge;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int AB = 2;
  localparam int DB = 4;
  localparam int TMO = 100;

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          busy, done, err;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;

  int checks = 0;
  int failures = 0;
  int n_done = 0;
  int n_err = 0;
  int tx_hs = 0;
  bit bp = 1'b0;
  bit exp_done = 1'b0;
  bit exp_err = 1'b0;
  bit exp_read = 1'b0;
  logic [DW-1:0] exp_rdata = '0;
  logic [7:0] exp_tx[$];
  bit stall_prev = 1'b0;
  logic [7:0] stall_data = '0;

  uart_mem_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_RETRY(2), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .res(res), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .err(err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transmitter backpressure: ready alternates when bp is set.
  initial forever begin
    @(posedge clk); #1;
    tx_ready = bp ? ~tx_ready : 1'b1;
  end

  // Monitor: every handshake, held byte, and done/err pulse.
  always @(negedge clk) begin
    if (!res) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("tx_valid_hold", tx_valid, 1'b1);
        check("tx_data_hold", tx_data, stall_data);
      end
      if (tx_valid && tx_ready) begin
        tx_hs++;
        if (exp_tx.size() == 0) check("tx_extra_byte", tx_data, 8'hxx);
        else check("tx_byte", tx_data, exp_tx.pop_front());
      end
      stall_prev = tx_valid && !tx_ready;
      stall_data = tx_data;
      if (done) begin
        n_done++;
        check("done_expected", exp_done, 1'b1);
        check("busy_at_done", busy, 1'b0);
        if (exp_read) check("rdata", rdata, exp_rdata);
        exp_done = 1'b0;
      end
      if (err) begin
        n_err++;
        check("err_expected", exp_err, 1'b1);
        check("busy_at_err", busy, 1'b0);
        check("rdata_hold_on_err", rdata, exp_rdata);
        exp_err = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Queue n literal bytes held MSB-first in v.
  task automatic push_lit(input int n, input logic [95:0] v);
    for (int k = 0; k < n; k++) exp_tx.push_back(v[(n-1-k)*8 +: 8]);
  endtask

  // Reference frame from the protocol rules.
  task automatic push_frame(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [7:0] b[$];
    logic [7:0] x;
    b.push_back(w ? 8'd4 : 8'd3);
    for (int i = AB - 1; i >= 0; i--) b.push_back(8'((32'(a) >> (8 * i)) & 32'hFF));
    if (w) for (int i = DB - 1; i >= 0; i--) b.push_back(8'((d >> (8 * i)) & 32'hFF));
`ifdef UART_MEM_CSUM_EN
    x = '0;
    foreach (b[i]) x = x ^ b[i];
    b.push_back(x);
`else
    x = '0;
`endif
    foreach (b[i]) exp_tx.push_back(b[i]);
  endtask

  task automatic send_rx(input int n, input logic [95:0] v);
    for (int k = 0; k < n; k++) begin
      rx_valid = 1'b1;
      rx_data  = v[(n-1-k)*8 +: 8];
      tick();
    end
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int c = 0;
    while (busy && c < 200) begin tick(); c++; end
    we = w; addr = a; wdata = d; req = 1'b1;
    tick();
    req = 1'b0;
    check("busy_after_req", busy, 1'b1);
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while (exp_tx.size() != 0 && c < budget) begin tick(); c++; end
    check("tx_drained", exp_tx.size(), 0);
  endtask

  task automatic wait_done(input int budget);
    int start = n_done;
    int c = 0;
    while (n_done == start && c < budget) begin tick(); c++; end
    check("done_seen", n_done - start, 1);
  endtask

  initial begin
    int c;
    int base;
    // Reset state
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_rdata", rdata, 32'h0);
    res = 1'b1;
    tick();

    // Write 1234 <= DEADBEEF, ACK
`ifdef UART_MEM_CSUM_EN
    push_lit(8, 64'h04_1234_DEADBEEF_00);
`else
    push_lit(7, 56'h04_1234_DEADBEEF);
`endif
    exp_read = 1'b0;
    issue(1'b1, 16'h1234, 32'hDEADBEEF);
    wait_drain(100);
    exp_done = 1'b1;
    send_rx(1, 8'h01);
    wait_done(50);
    check("write_busy_after", busy, 1'b0);
    check("write_done_pulse", done, 1'b0);

    // Read 00A0 => CAFEBABE
`ifdef UART_MEM_CSUM_EN
    push_lit(4, 32'h0300A0A3);
`else
    push_lit(3, 24'h0300A0);
`endif
    issue(1'b0, 16'h00A0, 32'h0);
    wait_drain(100);
    exp_read = 1'b1; exp_rdata = 32'hCAFEBABE; exp_done = 1'b1;
`ifdef UART_MEM_CSUM_EN
    send_rx(6, 48'h01CAFEBABE31);   // 31 = 01^CA^FE^BA^BE
`else
    send_rx(5, 40'h01CAFEBABE);
`endif
    wait_done(50);
    check("read_rdata_final", rdata, 32'hCAFEBABE);
    exp_read = 1'b0;

    // RESEND then ACK; a req while busy must not disturb the frame
    push_frame(1'b1, 16'hBEEF, 32'h0BADF00D);
    issue(1'b1, 16'hBEEF, 32'h0BADF00D);
    we = 1'b0; addr = 16'hFFFF; wdata = 32'hFFFFFFFF; req = 1'b1;
    tick();
    req = 1'b0;
    wait_drain(100);
    push_frame(1'b1, 16'hBEEF, 32'h0BADF00D);
    send_rx(1, 8'h02);
    wait_drain(100);
    exp_done = 1'b1;
    send_rx(1, 8'h01);
    wait_done(50);

    // No reply: three attempts, then err one retry-decision cycle after the window
    push_frame(1'b1, 16'h0042, 32'h11223344);
    issue(1'b1, 16'h0042, 32'h11223344);
    wait_drain(100);
    push_frame(1'b1, 16'h0042, 32'h11223344);
    wait_drain(500);
    push_frame(1'b1, 16'h0042, 32'h11223344);
    wait_drain(500);
    exp_err = 1'b1;
    c = 0;
    while (!err && c < 500) begin tick(); c++; end
    check("err_latency", c, TMO + 1);
    tick();
    check("err_count", n_err, 1);
    check("done_count", n_done, 3);

`ifdef UART_MEM_CSUM_EN
    // Bad response checksum forces a retransmit
    push_lit(4, 32'h03123425);
    issue(1'b0, 16'h1234, 32'h0);
    wait_drain(100);
    push_lit(4, 32'h03123425);
    send_rx(6, 48'h01CAFEBABE00);
    wait_drain(100);
    exp_read = 1'b1; exp_rdata = 32'hCAFEBABE; exp_done = 1'b1;
    send_rx(6, 48'h01CAFEBABE31);
    wait_done(50);
    exp_read = 1'b0;
`endif

    // Backpressure, then reset during the third byte
    bp = 1'b1;
    push_frame(1'b1, 16'h5A5A, 32'h01234567);
    issue(1'b1, 16'h5A5A, 32'h01234567);
    base = tx_hs;
    c = 0;
    while (tx_hs < base + 2 && c < 100) begin tick(); c++; end
    check("bp_two_bytes", tx_hs - base, 2);
    res = 1'b0;
    tick();
    exp_tx.delete();
    check("mid_rst_tx_valid", tx_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_tx_data", tx_data, 8'h00);
    check("mid_rst_rdata", rdata, 32'h0);
    res = 1'b1;
    bp = 1'b0;
    repeat (20) tick();
    check("post_rst_idle", busy, 1'b0);
    check("post_rst_no_tx", exp_tx.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
